// File: rtl/l2_slow_memory_if.sv
// rtl/l2_slow_memory_if.sv - block request/response bus and write tap of the L2 backing memory model
interface l2_slow_memory_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic [29:0]  tap_addr;
  logic [31:0]  tap_data;
  logic         tap_wen;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata,
    input  tap_addr,
    input  tap_data,
    input  tap_wen
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata,
    output tap_addr,
    output tap_data,
    output tap_wen
  );
endinterface

// File: rtl/l2_slow_memory.sv
// rtl/l2_slow_memory.sv - fixed-latency 128-bit block memory with word-granular write replay tap
module l2_slow_memory #(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst,
  l2_slow_memory_if.slave    mem_bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, TAP} state_e;

  localparam logic [7:0] LAT_C = 8'(LATENCY);

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [27:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           wr_q, wr_d;
  logic [2:0]     tap_cnt_q, tap_cnt_d;
  logic [29:0]    tap_addr_q, tap_addr_d;
  logic [31:0]    tap_data_q, tap_data_d;
  logic           tap_wen_q, tap_wen_d;

  logic [127:0]   mem_q [0:(1 << DEPTH_LOG2) - 1];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  done_cycle;
  logic [2:0]            tap_nxt;

  assign idx        = addr_q[DEPTH_LOG2-1:0];
  assign done_cycle = (state_q == BUSY) && (cnt_q == LAT_C);
  assign tap_nxt    = tap_cnt_q + 3'd1;

  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] i);
    return blk[{i, 5'b00000} +: 32];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      tap_cnt_q  <= '0;
      tap_addr_q <= '0;
      tap_data_q <= '0;
      tap_wen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      tap_cnt_q  <= tap_cnt_d;
      tap_addr_q <= tap_addr_d;
      tap_data_q <= tap_data_d;
      tap_wen_q  <= tap_wen_d;
    end
  end

  // Storage survives reset; an aborted write never reaches done_cycle, so nothing commits.
  always_ff @(posedge clk) begin
    if (done_cycle && wr_q) begin
      mem_q[idx] <= wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    tap_cnt_d  = tap_cnt_q;
    tap_addr_d = tap_addr_q;
    tap_data_d = tap_data_q;
    tap_wen_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_bus.mem_write || mem_bus.mem_read) begin
          addr_d  = mem_bus.mem_addr;
          wdata_d = mem_bus.mem_wdata;
          wr_d    = mem_bus.mem_write;
          cnt_d   = 8'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAT_C) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (wr_q) begin
          state_d    = TAP;
          tap_cnt_d  = 3'd0;
          tap_wen_d  = 1'b1;
          tap_addr_d = {addr_q, 2'd0};
          tap_data_d = word_of(wdata_q, 2'd0);
        end else begin
          state_d = IDLE;
        end
      end
      TAP: begin
        // Even tap_cnt cycles strobe, odd ones are the gap the checker needs between words.
        if (tap_cnt_q == 3'd7) begin
          state_d = IDLE;
        end else begin
          tap_cnt_d = tap_nxt;
          if (tap_cnt_q[0]) begin
            tap_wen_d  = 1'b1;
            tap_addr_d = {addr_q, tap_nxt[2:1]};
            tap_data_d = word_of(wdata_q, tap_nxt[2:1]);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_bus.mem_ready = done_cycle;
  assign mem_bus.mem_rdata = (done_cycle && !wr_q) ? mem_q[idx] : '0;
  assign mem_bus.tap_addr  = tap_addr_q;
  assign mem_bus.tap_data  = tap_data_q;
  assign mem_bus.tap_wen   = tap_wen_q;

endmodule

// File: doc/l2_slow_memory.md
Name: l2_slow_memory

Overview:
- Cycle-accurate main-memory model behind the L2 cache in the extension testbench.
- Serves 128-bit block reads and writes with a fixed, parameterised latency and a one-cycle ready pulse.
- After each committed block write, replays the four written words as word-granular write strobes on a tap port. The tap port drives the testbench result checker's addr/data/wen inputs directly.
- Tap strobes are spaced so the checker's one-count-per-wen-pulse logic sees each word exactly once.

Parameters:
LATENCY, 10, cycles from request accept to mem_ready pulse (legal range 1..255)
DEPTH_LOG2, 8, log2 of number of 128-bit blocks stored

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
mem_read  input  1  block read request, level, held by requester until mem_ready
mem_write  input  1  block write request, level, held by requester until mem_ready
mem_addr  input  28  block address (word address bits [29:2])
mem_wdata  input  128  write block; word i = bits [32i+31:32i]
mem_ready  output  1  one-cycle completion pulse
mem_rdata  output  128  read block, valid only in the mem_ready cycle of a read
tap_addr  output  30  word address of tapped write
tap_data  output  32  tapped word
tap_wen  output  1  tap write strobe

Behaviour:
- Reset (rst low, any state, async): FSM to IDLE; latency counter = 0; mem_ready = 0; mem_rdata = 0; tap_addr = 0; tap_data = 0; tap_wen = 0.
  - Storage array is not cleared by reset. The bench preloads it hierarchically.
  - A request in flight at reset is dropped; no write is committed.
- Storage: 2^DEPTH_LOG2 entries x 128 bits, indexed by mem_addr[DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias.
- States: IDLE, BUSY, DONE, TAP.
- IDLE:
  - If mem_write or mem_read is high: latch addr, wdata and op; counter = 1; go to BUSY.
  - Write has priority when both are high; the read is ignored and must be re-requested.
- BUSY:
  - Inputs are ignored (latched copies are used). Counter increments each cycle.
  - When counter == LATENCY: assert mem_ready for this cycle only.
    - Read: drive mem_rdata = array[latched index].
    - Write: commit latched wdata to the array on this clock edge.
  - Next state: DONE.
  - Latency definition: request high in IDLE at edge N gives mem_ready high during cycle N+LATENCY. For LATENCY = 1, ready is the cycle immediately after accept.
- DONE: one turnaround cycle in which no request is accepted, so a request still held high is not re-accepted. Next state: TAP if the completed op was a write, otherwise IDLE.
- TAP:
  - 8 cycles. For i = 0..3: one cycle with tap_wen = 1, tap_addr = {latched addr, i[1:0]}, tap_data = word i; then one cycle with tap_wen = 0.
  - tap_addr/tap_data hold their last values when tap_wen = 0.
  - Then go to IDLE. Requests are not accepted during TAP.
- Outside TAP, tap_wen = 0. mem_rdata returns to 0 after the ready cycle.
- Minimum spacing between mem_ready pulses is LATENCY+2 cycles for reads and LATENCY+10 cycles for writes.
- A read issued after a write to the same index returns the newly written data: the commit precedes the read accept.

Test Plan:
- Preload index 5 = 128'h4444_4444_3333_3333_2222_2222_1111_1111; hold mem_read, addr 28'h5; LATENCY=10 -> mem_ready high exactly in cycle 10 after accept; mem_rdata = preload; mem_rdata = 0 the next cycle; no second ready while read is still held during DONE.
- Write addr 28'h3F, wdata words {0x932, 7, 8, 0x00000D5D} (word0 first) -> mem_ready after 10 cycles; then tap_wen pulses high/low four times with tap_addr 0xFC, 0xFD, 0xFE, 0xFF and tap_data 0x932, 7, 8, 0xD5D; read-back of 28'h3F returns the same block.
- mem_read and mem_write both high, addr 2 -> write committed, tap sequence emitted, no read data returned; a subsequent read of addr 2 returns the written block.
- Write in flight, rst pulled low at counter=6 -> all outputs 0 immediately; after release no mem_ready and no tap pulses; array at that index unchanged.
- DEPTH_LOG2=8: write addr 28'h105 -> read addr 28'h005 returns the same data (aliasing).
- LATENCY=1: back-to-back held reads -> ready pulses exactly 3 cycles apart.
